pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage cotm32 pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC-hold and PC-source select. It resolves load-use hazards, EX branch redirects, LSU and fetch wait states, and trap/mret redirects from MEM. A small FSM and a post-redirect bubble counter sequence the multi-cycle cases.

Parameters:
REDIRECT_BUBBLES, 1, extra cycles IF/ID is flushed after a trap/mret redirect to cover synchronous IMEM latency; range 0..7.
REG_ADDR_W, 5, register index width.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_id_rs1  in  REG_ADDR_W  ID source register 1
i_id_rs2  in  REG_ADDR_W  ID source register 2
i_id_uses_rs1  in  1  ID instruction reads rs1
i_id_uses_rs2  in  1  ID instruction reads rs2
i_ex_valid  in  1  EX holds a valid instruction
i_ex_rd  in  REG_ADDR_W  EX destination register
i_ex_is_load  in  1  EX instruction is a load
i_ex_branch_taken  in  1  EX resolved a taken branch or jump
i_mem_valid  in  1  MEM holds a valid instruction
i_mem_trap  in  1  OR of MEM trap flags (misaligned, access fault, illegal, ebreak, ecall)
i_mem_mret  in  1  MEM instruction is mret
i_lsu_busy  in  1  LSU access outstanding; MEM cannot advance
i_if_busy  in  1  fetch not ready this cycle
o_stall_pc  out  1  hold PC
o_stall_ifid, o_stall_idex, o_stall_exmem, o_stall_memwb  out  1 each  hold the register
o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb  out  1 each  load a NOP/invalid bubble
o_pc_sel  out  pc_sel_t (2)  PC_SEL_SEQ / PC_SEL_BRANCH / PC_SEL_TRAP / PC_SEL_MRET
o_trap_ack  out  1  one-cycle pulse: trap entry committed (CSR unit updates mepc/mcause)
o_mret_ack  out  1  one-cycle pulse: mret committed

Behaviour:
- All outputs are combinational from state plus inputs. State is st (ST_RUN, ST_DRAIN) and bubble counter bcnt (3 bits).
- Reset: st=ST_RUN, bcnt=0. While i_rst=1, all o_flush_*=1, all o_stall_*=0, o_pc_sel=SEQ, acks=0.
- Flush overrides stall for the same register.
- Priority per cycle in ST_RUN, highest first:
  1. Trap/mret: i_mem_valid & (i_mem_trap | i_mem_mret).
     - If i_lsu_busy=1: stall PC and all four registers; next st=ST_DRAIN.
     - Otherwise: flush ifid, idex, exmem and memwb (the trapping instruction does not retire). o_pc_sel=TRAP, or MRET if i_mem_mret. Pulse the matching ack. Load bcnt=REDIRECT_BUBBLES.
     - If i_mem_trap and i_mem_mret are both set, trap wins.
  2. LSU wait: i_lsu_busy=1. Stall PC, ifid, idex and exmem; flush memwb. o_pc_sel=SEQ. A concurrent EX branch is not taken this cycle; it fires after release because EX holds.
  3. Branch: i_ex_branch_taken & i_ex_valid. Flush ifid and idex; o_pc_sel=BRANCH. A concurrent load-use hazard is ignored because the ID instruction is on the wrong path.
  4. Load-use: i_ex_valid & i_ex_is_load & i_ex_rd!=0 & ((i_id_uses_rs1 & rs1==rd) | (i_id_uses_rs2 & rs2==rd)). Stall PC and ifid; flush idex. Exactly one bubble, because next cycle the load is in MEM.
  5. Fetch wait: i_if_busy=1. Stall PC; flush ifid.
  6. Otherwise: no stall, no flush, SEQ.
- ST_DRAIN:
  - Stall PC and all registers; acks=0.
  - When i_lsu_busy=0, perform the item-1 commit in that same cycle and return to ST_RUN.
  - If the MEM request disappears (i_mem_valid=0), return to ST_RUN with no action.
- Bubble counter:
  - While bcnt!=0 in ST_RUN, o_flush_ifid=1 in addition to any other outputs, and bcnt decrements by 1.
  - A new trap/mret commit reloads bcnt and does not accumulate.
  - bcnt saturates at 0.
- Reset asserted mid-DRAIN or mid-countdown returns to ST_RUN with bcnt=0 on the next edge.

Decomposition:
- cotm32_pipeline_pkg gains:
  - pc_sel_t enum: SEQ=0, BRANCH=1, TRAP=2, MRET=3.
  - pipe_ctrl_state_t enum: ST_RUN, ST_DRAIN.
- Sub-module pipeline_hazard_detect: purely combinational load-use comparator (rs1/rs2/rd/uses/is_load/valid in, o_load_use out). It is reused by the forwarding unit.

Test Plan:
- Load-use: EX is a load with rd=5; ID has rs2=5 and uses_rs2=1 -> exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1, then the next cycle shows all zeros. The same case with rd=0 -> no stall.
- Branch plus load-use in the same cycle -> flush_ifid=flush_idex=1, pc_sel=BRANCH, stall_pc=0.
- Trap with REDIRECT_BUBBLES=2, lsu_busy=0 -> cycle T: all four flushes, pc_sel=TRAP, trap_ack=1. Cycles T+1 and T+2: flush_ifid=1 only. Cycle T+3: clean.
- Trap while lsu_busy=1 for 3 cycles -> 3 cycles of full stall with acks=0. In the 4th cycle (busy=0): commit, trap_ack pulses once, pc_sel=TRAP.
- LSU busy plus EX branch taken -> pc_sel=SEQ and flush_memwb=1 while busy. In the first cycle after release: pc_sel=BRANCH.
- mret asserted in DRAIN, then i_rst high for 1 cycle -> all flushes=1, no ack. After reset: st=ST_RUN, bcnt=0, outputs idle.

Source files
------------

// File: rtl/cotm32_pipeline_pkg.sv
// Shared pipeline-control types for the cotm32 core: PC source select and
// the stall/flush controller state.
package cotm32_pipeline_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_TRAP   = 2'd2,
        PC_SEL_MRET   = 2'd3
    } pc_sel_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } pipe_ctrl_state_t;

    localparam int unsigned BCNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Purely combinational; shared with forwarding.
module pipeline_hazard_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  i_valid,
    input  logic                  i_is_load,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic                  i_uses_rs1,
    input  logic                  i_uses_rs2,
    output logic                  o_load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign rs1_hit    = i_uses_rs1 && (i_rs1 == i_rd);
    assign rs2_hit    = i_uses_rs2 && (i_rs2 == i_rd);
    assign o_load_use = i_valid && i_is_load && (i_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage cotm32 pipeline: load-use,
// branch redirect, LSU/fetch waits and trap/mret redirects from MEM.
module pipeline_ctrl
    import cotm32_pipeline_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned REG_ADDR_W       = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic                  i_ex_valid,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_is_load,
    input  logic                  i_ex_branch_taken,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_trap,
    input  logic                  i_mem_mret,
    input  logic                  i_lsu_busy,
    input  logic                  i_if_busy,
    output logic                  o_stall_pc,
    output logic                  o_stall_ifid,
    output logic                  o_stall_idex,
    output logic                  o_stall_exmem,
    output logic                  o_stall_memwb,
    output logic                  o_flush_ifid,
    output logic                  o_flush_idex,
    output logic                  o_flush_exmem,
    output logic                  o_flush_memwb,
    output pc_sel_t               o_pc_sel,
    output logic                  o_trap_ack,
    output logic                  o_mret_ack
);

    pipe_ctrl_state_t    st_q, st_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    logic load_use;
    logic redirect_req;
    logic commit;
    logic stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;

    pipeline_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .i_valid    (i_ex_valid),
        .i_is_load  (i_ex_is_load),
        .i_rd       (i_ex_rd),
        .i_rs1      (i_id_rs1),
        .i_rs2      (i_id_rs2),
        .i_uses_rs1 (i_id_uses_rs1),
        .i_uses_rs2 (i_id_uses_rs2),
        .o_load_use (load_use)
    );

    // A redirect commits in either state as soon as the LSU is free
    assign redirect_req = i_mem_valid && (i_mem_trap || i_mem_mret);
    assign commit       = !i_rst && redirect_req && !i_lsu_busy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_q   <= ST_RUN;
            bcnt_q <= '0;
        end else begin
            st_q   <= st_d;
            bcnt_q <= bcnt_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        bcnt_d = bcnt_q;
        if (commit) begin
            st_d   = ST_RUN;
            bcnt_d = BCNT_W'(REDIRECT_BUBBLES);
        end else begin
            case (st_q)
                ST_RUN: begin
                    if (redirect_req && i_lsu_busy) st_d = ST_DRAIN;
                    if (bcnt_q != '0) bcnt_d = bcnt_q - 1'b1;
                end
                ST_DRAIN: begin
                    if (!redirect_req) st_d = ST_RUN;
                end
                default: st_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_pc      = 1'b0;
        stall_ifid    = 1'b0;
        stall_idex    = 1'b0;
        stall_exmem   = 1'b0;
        stall_memwb   = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        o_flush_exmem = 1'b0;
        o_flush_memwb = 1'b0;
        o_pc_sel      = PC_SEL_SEQ;
        o_trap_ack    = 1'b0;
        o_mret_ack    = 1'b0;

        if (i_rst) begin
            o_flush_ifid  = 1'b1;
            o_flush_idex  = 1'b1;
            o_flush_exmem = 1'b1;
            o_flush_memwb = 1'b1;
        end else if (redirect_req && (st_q == ST_DRAIN || st_q == ST_RUN)) begin
            if (i_lsu_busy) begin
                {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb} = '1;
            end else begin
                // Trapping instruction does not retire; trap beats mret
                {o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb} = '1;
                o_pc_sel   = i_mem_trap ? PC_SEL_TRAP : PC_SEL_MRET;
                o_trap_ack = i_mem_trap;
                o_mret_ack = !i_mem_trap;
            end
        end else if (st_q == ST_RUN) begin
            if (i_lsu_busy) begin
                {stall_pc, stall_ifid, stall_idex, stall_exmem} = '1;
                o_flush_memwb = 1'b1;
            end else if (i_ex_branch_taken && i_ex_valid) begin
                o_flush_ifid = 1'b1;
                o_flush_idex = 1'b1;
                o_pc_sel     = PC_SEL_BRANCH;
            end else if (load_use) begin
                stall_pc     = 1'b1;
                stall_ifid   = 1'b1;
                o_flush_idex = 1'b1;
            end else if (i_if_busy) begin
                stall_pc     = 1'b1;
                o_flush_ifid = 1'b1;
            end
        end

        // Post-redirect bubbles cover the synchronous IMEM read latency
        if (!i_rst && st_q == ST_RUN && bcnt_q != '0) o_flush_ifid = 1'b1;
    end

    assign o_stall_pc    = stall_pc;
    assign o_stall_ifid  = stall_ifid  && !o_flush_ifid;
    assign o_stall_idex  = stall_idex  && !o_flush_idex;
    assign o_stall_exmem = stall_exmem && !o_flush_exmem;
    assign o_stall_memwb = stall_memwb && !o_flush_memwb;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl with REDIRECT_BUBBLES=2: expected output
// vectors are queued as stimulus is applied and popped when sampled.
module tb_pipeline_ctrl;
    import cotm32_pipeline_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
    logic       i_id_uses_rs1, i_id_uses_rs2, i_ex_valid, i_ex_is_load;
    logic       i_ex_branch_taken, i_mem_valid, i_mem_trap, i_mem_mret;
    logic       i_lsu_busy, i_if_busy;
    logic       o_stall_pc, o_stall_ifid, o_stall_idex, o_stall_exmem, o_stall_memwb;
    logic       o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb;
    pc_sel_t    o_pc_sel;
    logic       o_trap_ack, o_mret_ack;

    int total = 0;
    int bad   = 0;
    logic [12:0] sb[$];

    // {stall pc,ifid,idex,exmem,memwb}_{flush ifid,idex,exmem,memwb}_{pc_sel}_{trap_ack,mret_ack}
    localparam logic [12:0] IDLE  = 13'b00000_0000_00_00;
    localparam logic [12:0] RST   = 13'b00000_1111_00_00;
    localparam logic [12:0] LU    = 13'b11000_0100_00_00;
    localparam logic [12:0] BR    = 13'b00000_1100_01_00;
    localparam logic [12:0] IFW   = 13'b10000_1000_00_00;
    localparam logic [12:0] LSUW  = 13'b11110_0001_00_00;
    localparam logic [12:0] STALL = 13'b11111_0000_00_00;
    localparam logic [12:0] TRAPC = 13'b00000_1111_10_10;
    localparam logic [12:0] MRETC = 13'b00000_1111_11_01;
    localparam logic [12:0] BUB   = 13'b00000_1000_00_00;

    pipeline_ctrl #(
        .REDIRECT_BUBBLES (2),
        .REG_ADDR_W       (5)
    ) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_id_rs1          (i_id_rs1),
        .i_id_rs2          (i_id_rs2),
        .i_id_uses_rs1     (i_id_uses_rs1),
        .i_id_uses_rs2     (i_id_uses_rs2),
        .i_ex_valid        (i_ex_valid),
        .i_ex_rd           (i_ex_rd),
        .i_ex_is_load      (i_ex_is_load),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_mem_valid       (i_mem_valid),
        .i_mem_trap        (i_mem_trap),
        .i_mem_mret        (i_mem_mret),
        .i_lsu_busy        (i_lsu_busy),
        .i_if_busy         (i_if_busy),
        .o_stall_pc        (o_stall_pc),
        .o_stall_ifid      (o_stall_ifid),
        .o_stall_idex      (o_stall_idex),
        .o_stall_exmem     (o_stall_exmem),
        .o_stall_memwb     (o_stall_memwb),
        .o_flush_ifid      (o_flush_ifid),
        .o_flush_idex      (o_flush_idex),
        .o_flush_exmem     (o_flush_exmem),
        .o_flush_memwb     (o_flush_memwb),
        .o_pc_sel          (o_pc_sel),
        .o_trap_ack        (o_trap_ack),
        .o_mret_ack        (o_mret_ack)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [12:0] obs();
        return {o_stall_pc, o_stall_ifid, o_stall_idex, o_stall_exmem, o_stall_memwb,
                o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb,
                o_pc_sel, o_trap_ack, o_mret_ack};
    endfunction

    task automatic set_idle();
        i_rst = 1'b0;
        i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rd = '0;
        i_id_uses_rs1 = 1'b0; i_id_uses_rs2 = 1'b0;
        i_ex_valid = 1'b0; i_ex_is_load = 1'b0; i_ex_branch_taken = 1'b0;
        i_mem_valid = 1'b0; i_mem_trap = 1'b0; i_mem_mret = 1'b0;
        i_lsu_busy = 1'b0; i_if_busy = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        for (int c = 0; c < 3; c++) begin
            set_idle();
            i_rst = (c < 2);
            sb.push_back(c < 2 ? RST : IDLE);
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL reset cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        logic [12:0] exp;
        for (int c = 0; c < 6; c++) begin
            set_idle();
            case (c)
                0: begin i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5; i_id_rs2 = 5; i_id_uses_rs2 = 1; sb.push_back(LU); end
                1: begin i_id_rs2 = 5; i_id_uses_rs2 = 1; sb.push_back(IDLE); end
                2: begin i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 0; i_id_rs2 = 0; i_id_uses_rs2 = 1; sb.push_back(IDLE); end
                3: begin i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 9; i_id_rs1 = 9; i_id_uses_rs1 = 1; sb.push_back(LU); end
                4: begin i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 9; i_id_rs1 = 9; i_id_uses_rs1 = 0; sb.push_back(IDLE); end
                default: begin i_ex_valid = 1; i_ex_is_load = 0; i_ex_rd = 7; i_id_rs1 = 7; i_id_uses_rs1 = 1; sb.push_back(IDLE); end
            endcase
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL load_use cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_branch_and_fetch();
        logic [12:0] exp;
        for (int c = 0; c < 3; c++) begin
            set_idle();
            case (c)
                0: begin
                    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5; i_id_rs1 = 5; i_id_uses_rs1 = 1;
                    i_ex_branch_taken = 1; sb.push_back(BR);
                end
                1: begin i_if_busy = 1; sb.push_back(IFW); end
                default: begin i_ex_branch_taken = 1; sb.push_back(IDLE); end
            endcase
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL branch_fetch cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_trap_bubbles();
        logic [12:0] exp;
        for (int c = 0; c < 4; c++) begin
            set_idle();
            if (c == 0) begin i_mem_valid = 1; i_mem_trap = 1; end
            sb.push_back(c == 0 ? TRAPC : (c < 3 ? BUB : IDLE));
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL trap_bubbles cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_trap_drain();
        logic [12:0] exp;
        for (int c = 0; c < 7; c++) begin
            set_idle();
            if (c <= 3) begin i_mem_valid = 1; i_mem_trap = 1; i_lsu_busy = (c < 3); end
            case (c)
                0, 1, 2: sb.push_back(STALL);
                3:       sb.push_back(TRAPC);
                4, 5:    sb.push_back(BUB);
                default: sb.push_back(IDLE);
            endcase
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL trap_drain cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_lsu_branch();
        logic [12:0] exp;
        for (int c = 0; c < 4; c++) begin
            set_idle();
            if (c < 3) begin i_ex_valid = 1; i_ex_branch_taken = 1; i_lsu_busy = (c < 2); end
            sb.push_back(c < 2 ? LSUW : (c == 2 ? BR : IDLE));
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL lsu_branch cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_mret_reset();
        logic [12:0] exp;
        for (int c = 0; c < 5; c++) begin
            set_idle();
            case (c)
                0: begin i_mem_valid = 1; i_mem_mret = 1; i_lsu_busy = 1; sb.push_back(STALL); end
                1: begin i_mem_valid = 1; i_mem_mret = 1; i_lsu_busy = 1; sb.push_back(STALL); end
                2: begin i_mem_valid = 1; i_mem_mret = 1; i_lsu_busy = 1; i_rst = 1; sb.push_back(RST); end
                3: sb.push_back(IDLE);
                default: begin i_lsu_busy = 1; sb.push_back(LSUW); end
            endcase
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL mret_reset cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_drain_abandon();
        logic [12:0] exp;
        for (int c = 0; c < 4; c++) begin
            set_idle();
            case (c)
                0: begin i_mem_valid = 1; i_mem_trap = 1; i_lsu_busy = 1; sb.push_back(STALL); end
                1: begin i_lsu_busy = 1; sb.push_back(IDLE); end
                2: begin i_lsu_busy = 1; sb.push_back(LSUW); end
                default: sb.push_back(IDLE);
            endcase
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL drain_abandon cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        for (int c = 0; c < 5; c++) begin
            set_idle();
            case (c)
                0: begin i_mem_valid = 1; i_mem_trap = 1; i_mem_mret = 1; sb.push_back(TRAPC); end
                1: begin i_mem_valid = 1; i_mem_mret = 1; sb.push_back(MRETC); end
                2, 3: sb.push_back(BUB);
                default: sb.push_back(IDLE);
            endcase
            @(negedge i_clk);
            exp = sb.pop_front();
            total++;
            if (obs() !== exp) begin bad++; $display("FAIL back_to_back cyc%0d got=%b want=%b", c, obs(), exp); end
            next_cycle();
        end
    endtask

    initial begin
        set_idle();
        i_rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch_and_fetch();
        test_trap_bubbles();
        test_trap_drain();
        test_lsu_branch();
        test_mret_reset();
        test_drain_abandon();
        test_back_to_back();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
